// File: rtl/sat_engine_pkg.sv
// Shared types and default constants for the sat engine array-collector logic.
package sat_engine_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StCheck,
    StReport,
    StAnalyze
  } collector_state_t;

  localparam int unsigned DefSettleCyc = 2;
  localparam int unsigned DefMaxRounds = 8;

endpackage

// File: rtl/lowest_one_enc.sv
// Combinational lowest-set-bit encoder; found is low and idx is 0 when vec is empty.
module lowest_one_enc #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 3
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         found
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/clause_status_collector.sv
// Snapshots the clause array terminal outputs after each BCP step until stable, then
// reports a conflict over valid/ready or signals BCP completion.
module clause_status_collector
  import sat_engine_pkg::*;
#(
  parameter int unsigned NUM_C      = 8,
  parameter int unsigned WIDTH_LVL  = 16,
  parameter int unsigned WIDTH_CID  = 3,
  parameter int unsigned SETTLE_CYC = DefSettleCyc,
  parameter int unsigned MAX_ROUNDS = DefMaxRounds
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_bcp_i,
  input  logic [NUM_C-1:0]           csat_drv_i,
  input  logic [NUM_C-1:0]           imp_drv_i,
  input  logic [NUM_C-1:0]           conflict_c_drv_i,
  input  logic [NUM_C*WIDTH_LVL-1:0] cmax_lvl_i,
  output logic                       conflict_valid_o,
  input  logic                       conflict_ready_i,
  output logic [WIDTH_CID-1:0]       conflict_cid_o,
  output logic [WIDTH_LVL-1:0]       conflict_lvl_o,
  output logic                       apply_analyze_o,
  input  logic                       analyze_done_i,
  output logic                       bcp_done_o,
  output logic                       all_c_sat_o,
  output logic                       timeout_o,
  output logic                       busy_o
);

  localparam logic [3:0] SettleInit = 4'(SETTLE_CYC - 1);
  localparam logic [7:0] MaxRnd     = 8'(MAX_ROUNDS);

  collector_state_t state_q;

  logic [3:0]                 settle_q;
  logic [7:0]                 round_q;
  logic [NUM_C-1:0]           snap_sat_q;
  logic [NUM_C-1:0]           snap_imp_q;
  logic [NUM_C-1:0]           snap_conf_q;
  logic [NUM_C*WIDTH_LVL-1:0] snap_lvl_q;
  logic [3*NUM_C-1:0]         prev_q;
  logic [WIDTH_CID-1:0]       cid_q;
  logic [WIDTH_LVL-1:0]       lvl_q;
  logic                       valid_q;
  logic                       analyze_q;
  logic                       bcp_done_q;
  logic                       all_sat_q;
  logic                       timeout_q;
  logic                       busy_q;

  logic [3*NUM_C-1:0]   snap_bits;
  logic [WIDTH_CID-1:0] enc_idx;
  logic                 enc_found;
  logic [WIDTH_LVL-1:0] sel_lvl;

  assign snap_bits = {snap_sat_q, snap_imp_q, snap_conf_q};

  lowest_one_enc #(
    .N(NUM_C),
    .W(WIDTH_CID)
  ) u_conf_enc (
    .vec  (snap_conf_q),
    .idx  (enc_idx),
    .found(enc_found)
  );

  always_comb begin
    sel_lvl = '0;
    for (int k = 0; k < NUM_C; k++) begin
      if (enc_idx == WIDTH_CID'(k)) begin
        sel_lvl = snap_lvl_q[k*WIDTH_LVL +: WIDTH_LVL];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      settle_q    <= '0;
      round_q     <= '0;
      snap_sat_q  <= '0;
      snap_imp_q  <= '0;
      snap_conf_q <= '0;
      snap_lvl_q  <= '0;
      prev_q      <= '0;
      cid_q       <= '0;
      lvl_q       <= '0;
      valid_q     <= 1'b0;
      analyze_q   <= 1'b0;
      bcp_done_q  <= 1'b0;
      all_sat_q   <= 1'b0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      bcp_done_q <= 1'b0;
      timeout_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_bcp_i) begin
            round_q   <= '0;
            settle_q  <= SettleInit;
            prev_q    <= '0;
            all_sat_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= StSettle;
          end
        end
        StSettle: begin
          if (settle_q == 4'd0) begin
            snap_sat_q  <= csat_drv_i;
            snap_imp_q  <= imp_drv_i;
            snap_conf_q <= conflict_c_drv_i;
            snap_lvl_q  <= cmax_lvl_i;
            state_q     <= StCheck;
          end else begin
            settle_q <= settle_q - 4'd1;
          end
        end
        StCheck: begin
          if (enc_found) begin
            cid_q   <= enc_idx;
            lvl_q   <= sel_lvl;
            valid_q <= 1'b1;
            state_q <= StReport;
          end else if (snap_bits != prev_q) begin
            prev_q  <= snap_bits;
            round_q <= round_q + 8'd1;
            if (round_q + 8'd1 == MaxRnd) begin
              timeout_q <= 1'b1;
              busy_q    <= 1'b0;
              state_q   <= StIdle;
            end else begin
              settle_q <= SettleInit;
              state_q  <= StSettle;
            end
          end else begin
            bcp_done_q <= 1'b1;
            all_sat_q  <= &snap_sat_q;
            busy_q     <= 1'b0;
            state_q    <= StIdle;
          end
        end
        StReport: begin
          // valid_q is always high here, so ready alone completes the handshake.
          if (conflict_ready_i) begin
            valid_q   <= 1'b0;
            analyze_q <= 1'b1;
            state_q   <= StAnalyze;
          end
        end
        StAnalyze: begin
          if (analyze_done_i) begin
            analyze_q <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign conflict_valid_o = valid_q;
  assign conflict_cid_o   = cid_q;
  assign conflict_lvl_o   = lvl_q;
  assign apply_analyze_o  = analyze_q;
  assign bcp_done_o       = bcp_done_q;
  assign all_c_sat_o      = all_sat_q;
  assign timeout_o        = timeout_q;
  assign busy_o           = busy_q;

endmodule

// File: tb/tb_clause_status_collector.sv
// Directed bench for clause_status_collector with a scoreboard of expected BCP outcomes.
module tb_clause_status_collector;

  localparam int NC = 8;
  localparam int WL = 16;
  localparam int WC = 3;

  logic           clk;
  logic           rst;
  logic           start;
  logic [NC-1:0]  csat;
  logic [NC-1:0]  imp;
  logic [NC-1:0]  conf;
  logic [NC*WL-1:0] lvl_bus;
  logic           conflict_valid;
  logic           conflict_ready;
  logic [WC-1:0]  conflict_cid;
  logic [WL-1:0]  conflict_lvl;
  logic           apply_analyze;
  logic           analyze_done;
  logic           bcp_done;
  logic           all_c_sat;
  logic           timeout;
  logic           busy;

  logic toggle_imp;
  int   total;
  int   bad;

  // kind: 0 = bcp done, 1 = conflict, 2 = timeout, 3 = nothing seen
  typedef struct {
    int          kind;
    logic [2:0]  cid;
    logic [15:0] lvl;
    logic        all_sat;
    int          lat;
  } exp_t;

  exp_t sb[$];

  clause_status_collector #(
    .NUM_C     (NC),
    .WIDTH_LVL (WL),
    .WIDTH_CID (WC),
    .SETTLE_CYC(2),
    .MAX_ROUNDS(4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start_bcp_i     (start),
    .csat_drv_i      (csat),
    .imp_drv_i       (imp),
    .conflict_c_drv_i(conf),
    .cmax_lvl_i      (lvl_bus),
    .conflict_valid_o(conflict_valid),
    .conflict_ready_i(conflict_ready),
    .conflict_cid_o  (conflict_cid),
    .conflict_lvl_o  (conflict_lvl),
    .apply_analyze_o (apply_analyze),
    .analyze_done_i  (analyze_done),
    .bcp_done_o      (bcp_done),
    .all_c_sat_o     (all_c_sat),
    .timeout_o       (timeout),
    .busy_o          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (toggle_imp) imp = ~imp;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push_exp(input int kind, input logic [2:0] cid, input logic [15:0] lvl,
                          input logic all_sat, input int lat);
    exp_t e;
    e.kind    = kind;
    e.cid     = cid;
    e.lvl     = lvl;
    e.all_sat = all_sat;
    e.lat     = lat;
    sb.push_back(e);
  endtask

  // Called right after the start edge; lat counts clock edges from that edge.
  task automatic wait_result(input string tag);
    int   lat;
    int   kind;
    exp_t e;
    lat  = 1;
    kind = 3;
    while (lat < 40) begin
      if (bcp_done) kind = 0;
      else if (conflict_valid) kind = 1;
      else if (timeout) kind = 2;
      if (kind != 3) break;
      tick();
      lat++;
    end
    e = sb.pop_front();
    check({tag, "_kind"}, 32'(kind), 32'(e.kind));
    check({tag, "_lat"}, 32'(lat), 32'(e.lat));
    if (e.kind == 0) check({tag, "_allsat"}, {31'd0, all_c_sat}, {31'd0, e.all_sat});
    if (e.kind == 1) begin
      check({tag, "_cid"}, {29'd0, conflict_cid}, {29'd0, e.cid});
      check({tag, "_lvl"}, {16'd0, conflict_lvl}, {16'd0, e.lvl});
    end
  endtask

  function automatic logic [31:0] outs();
    return {10'd0, conflict_valid, apply_analyze, bcp_done, all_c_sat, timeout, busy,
            conflict_cid, conflict_lvl[12:0]} | {31'd0, |conflict_lvl};
  endfunction

  initial begin
    total          = 0;
    bad            = 0;
    toggle_imp     = 1'b0;
    rst            = 1'b0;
    start          = 1'b0;
    csat           = '0;
    imp            = '0;
    conf           = '0;
    lvl_bus        = '0;
    conflict_ready = 1'b0;
    analyze_done   = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", outs(), 32'd0);
    rst = 1'b1;
    tick();
    check("idle_outs", outs(), 32'd0);

    // Constant all-sat snapshot: needs two rounds since round 1 compares against zero.
    csat = 8'hFF;
    push_exp(0, 3'd0, 16'd0, 1'b1, 7);
    pulse_start();
    check("s1_busy", {31'd0, busy}, 32'd1);
    wait_result("s1");
    check("s1_busy_end", {31'd0, busy}, 32'd0);
    tick();
    check("s1_done_pulse", {31'd0, bcp_done}, 32'd0);
    check("s1_allsat_hold", {31'd0, all_c_sat}, 32'd1);

    // Conflict on clauses 2 and 5; lowest index wins.
    csat = 8'h00;
    conf = 8'b0010_0100;
    lvl_bus[2*WL +: WL] = 16'd5;
    lvl_bus[5*WL +: WL] = 16'd9;
    push_exp(1, 3'd2, 16'd5, 1'b0, 4);
    pulse_start();
    check("s2_allsat_cleared", {31'd0, all_c_sat}, 32'd0);
    wait_result("s2");
    conf = 8'h01;
    lvl_bus[0 +: WL] = 16'd7;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) start = 1'b1;
      tick();
      start = 1'b0;
      check("s2_hold_valid", {31'd0, conflict_valid}, 32'd1);
      check("s2_hold_cid", {29'd0, conflict_cid}, 32'd2);
      check("s2_hold_lvl", {16'd0, conflict_lvl}, 32'd5);
      check("s2_no_analyze", {31'd0, apply_analyze}, 32'd0);
    end
    conflict_ready = 1'b1;
    tick();
    conflict_ready = 1'b0;
    check("s2_valid_drop", {31'd0, conflict_valid}, 32'd0);
    check("s2_analyze_on", {31'd0, apply_analyze}, 32'd1);
    tick();
    check("s2_analyze_hold", {31'd0, apply_analyze}, 32'd1);
    analyze_done = 1'b1;
    tick();
    analyze_done = 1'b0;
    check("s2_analyze_off", {31'd0, apply_analyze}, 32'd0);
    check("s2_busy_off", {31'd0, busy}, 32'd0);

    // Implications flip every cycle, so the snapshot never settles.
    conf       = 8'h00;
    imp        = 8'h0F;
    toggle_imp = 1'b1;
    push_exp(2, 3'd0, 16'd0, 1'b0, 13);
    pulse_start();
    wait_result("s3");
    toggle_imp = 1'b0;
    check("s3_busy", {31'd0, busy}, 32'd0);
    check("s3_no_done", {31'd0, bcp_done}, 32'd0);
    tick();
    check("s3_to_pulse", {31'd0, timeout}, 32'd0);
    check("s3_no_done2", {31'd0, bcp_done}, 32'd0);

    // Stable snapshot with clause 3 unsatisfied.
    imp  = 8'h00;
    csat = 8'hF7;
    push_exp(0, 3'd0, 16'd0, 1'b0, 7);
    pulse_start();
    wait_result("s4");

    // Async reset while idle with all_c_sat held high.
    csat = 8'hFF;
    push_exp(0, 3'd0, 16'd0, 1'b1, 7);
    pulse_start();
    wait_result("s5");
    #1;
    rst = 1'b0;
    #1;
    check("s5_rst_idle", outs(), 32'd0);
    rst = 1'b1;
    tick();

    // Async reset during SETTLE aborts immediately.
    pulse_start();
    check("s6_busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    check("s6_rst_settle", outs(), 32'd0);
    rst = 1'b1;
    tick();
    check("s6_after_rel", outs(), 32'd0);

    // Fresh start after reset behaves like the first run.
    push_exp(0, 3'd0, 16'd0, 1'b1, 7);
    pulse_start();
    wait_result("s7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
